// File: rtl/wb_arb_param_if.sv
// Bus bundle between requesting masters and the wb_arb_param arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface wb_arb_param_if #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
);
  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic                   timeout_evt;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  timeout_evt
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_idx,
    output timeout_evt
  );
endinterface

// File: rtl/wb_arb_param.sv
// Parameterised bus arbiter: round-robin or fixed priority, registered one-hot grant.
// Define WB_ARB_TIMEOUT_EN to compile in the contended-ownership hold counter and timeout_evt.
module wb_arb_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int IDX_W          = 2,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  wb_arb_param_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("wb_arb_param: NUM_MASTERS out of range");
  end
  if (IDX_W != $clog2(NUM_MASTERS)) begin : g_bad_idx_w
    $error("wb_arb_param: IDX_W must equal clog2(NUM_MASTERS)");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arb_param: TIMEOUT_CYCLES out of range");
  end

  // Round-robin scans ptr+1 .. ptr (wrapping); fixed priority ignores ptr.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                   input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               j;
    win   = ptr;
    found = 1'b0;
    if (FIXED_PRIO != 0) begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (req[k]) win = IDX_W'(k);
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        j = (int'(ptr) + k) % NUM_MASTERS;
        if (!found && req[j]) begin
          win   = IDX_W'(j);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  state_e                 state_d, state_q;
  logic [NUM_MASTERS-1:0] grant_d, grant_q;
  logic                   valid_d, valid_q;
  logic [IDX_W-1:0]       idx_d, idx_q;
  logic [IDX_W-1:0]       last_owner_d, last_owner_q;

  logic                   owner_req;
  logic                   new_grant;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       winner_ex;
  logic                   timeout_hit;

  assign owner_req = |(bus.request & grant_q);
  assign winner    = pick_winner(bus.request, last_owner_q);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_MAX = 16'(TIMEOUT_CYCLES - 1);

  logic [NUM_MASTERS-1:0] others;
  logic [15:0]            hold_cnt_d, hold_cnt_q;
  logic                   timeout_evt_d, timeout_evt_q;

  // A timed-out owner is skipped by masking its own request out of the search.
  assign others      = bus.request & ~grant_q;
  assign winner_ex   = pick_winner(others, last_owner_q);
  assign timeout_hit = (state_q == BUSY) && owner_req && (|others) && (hold_cnt_q == HOLD_MAX);
`else
  assign winner_ex   = winner;
  assign timeout_hit = 1'b0;
`endif

  // Next-state, next-grant and last-owner selection.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    valid_d      = valid_q;
    idx_d        = idx_q;
    last_owner_d = last_owner_q;
    new_grant    = 1'b0;
    next_idx     = winner;
    case (state_q)
      IDLE: begin
        if (|bus.request) begin
          new_grant = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          if (|bus.request) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else if (timeout_hit) begin
          new_grant = 1'b1;
          next_idx  = winner_ex;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
    if (new_grant) begin
      state_d      = BUSY;
      grant_d      = ONE_HOT_0 << next_idx;
      valid_d      = 1'b1;
      idx_d        = next_idx;
      last_owner_d = next_idx;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Arbiter state and registered outputs; reset takes effect without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      last_owner_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Counter restarts on any grant change and saturates while the owner holds on.
  always_comb begin
    timeout_evt_d = timeout_hit;
    if (grant_d != grant_q) begin
      hold_cnt_d = 16'd0;
    end else if ((state_q == BUSY) && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q    <= 16'd0;
      timeout_evt_q <= 1'b0;
    end else begin
      hold_cnt_q    <= hold_cnt_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign bus.timeout_evt = timeout_evt_q;
`else
  assign bus.timeout_evt = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_wb_arb_param.sv
// Scoreboard bench for wb_arb_param: round-robin and fixed-priority instances, 4 masters.
// Stimulus pushes hand-computed expectations; monitors pop and compare after each rising edge.
module tb_wb_arb_param;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_arb_param_if #(.NUM_MASTERS(4), .IDX_W(2)) bus_a ();
  wb_arb_param_if #(.NUM_MASTERS(4), .IDX_W(2)) bus_b ();

  wb_arb_param #(.NUM_MASTERS(4), .IDX_W(2), .FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  wb_arb_param #(.NUM_MASTERS(4), .IDX_W(2), .FIXED_PRIO(1), .TIMEOUT_CYCLES(64)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t q_async[$];
  int   checks   = 0;
  int   failures = 0;
  event async_ev;

  function automatic logic [7:0] pk(input logic [3:0] g, input logic v, input logic [1:0] i,
                                    input logic t);
    return {g, v, i, t};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual grant=%b valid=%b idx=%0d tevt=%b, required grant=%b valid=%b idx=%0d tevt=%b",
               name, act[7:4], act[3], act[2:1], act[0], exp[7:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Monitor: pop one expectation per instance after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        check(e.name, pk(bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, bus_a.timeout_evt), e.exp);
      end
      if (q_fp.size() > 0) begin
        e = q_fp.pop_front();
        check(e.name, pk(bus_b.grant, bus_b.grant_valid, bus_b.grant_idx, bus_b.timeout_evt), e.exp);
      end
    end
  end

  // Monitor for checks that must happen between clock edges.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      if (q_async.size() > 0) begin
        e = q_async.pop_front();
        check(e.name, pk(bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, bus_a.timeout_evt), e.exp);
      end
    end
  end

  task automatic drive_rr(input logic r_rst, input logic [3:0] r, input logic [7:0] e, input string n);
    @(negedge clk);
    rst           = r_rst;
    bus_a.request = r;
    q_rr.push_back('{n, e});
  endtask

  task automatic drive_fp(input logic [3:0] r, input logic [7:0] e, input string n);
    @(negedge clk);
    bus_b.request = r;
    q_fp.push_back('{n, e});
  endtask

  initial begin
    logic [3:0] one;
    int         o;
    one           = 4'b0001;
    rst           = 1'b1;
    bus_a.request = 4'b0000;
    bus_b.request = 4'b0000;

    drive_rr(1'b1, 4'b0000, pk(4'b0000, 1'b0, 2'd0, 1'b0), "rst_held");
    drive_rr(1'b1, 4'b0000, pk(4'b0000, 1'b0, 2'd0, 1'b0), "rst_held");
    for (int i = 0; i < 10; i++) begin
      drive_rr(1'b0, 4'b0000, pk(4'b0000, 1'b0, 2'd0, 1'b0), "idle_after_rst");
    end

    drive_rr(1'b0, 4'b0110, pk(4'b0010, 1'b1, 2'd1, 1'b0), "first_rr_grant");
    drive_rr(1'b0, 4'b0010, pk(4'b0010, 1'b1, 2'd1, 1'b0), "hold_owner1");
    drive_rr(1'b0, 4'b1001, pk(4'b1000, 1'b1, 2'd3, 1'b0), "handover_no_gap");
    drive_rr(1'b0, 4'b0000, pk(4'b0000, 1'b0, 2'd3, 1'b0), "idle_idx_held");
    drive_rr(1'b0, 4'b1111, pk(4'b0001, 1'b1, 2'd0, 1'b0), "rr_after_owner3");

    // All four masters keep requesting.
    for (int c = 1; c <= 16; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
      o = (c / 4) % 4;
      drive_rr(1'b0, 4'b1111, pk(one << o, 1'b1, 2'(o), (c % 4) == 0), "timeout_rotation");
`else
      o = 0;
      drive_rr(1'b0, 4'b1111, pk(one << o, 1'b1, 2'(o), 1'b0), "contended_hold");
`endif
    end

    for (int i = 0; i < 6; i++) begin
      drive_rr(1'b0, 4'b0001, pk(4'b0001, 1'b1, 2'd0, 1'b0), "uncontested_hold");
    end
    drive_rr(1'b0, 4'b0000, pk(4'b0000, 1'b0, 2'd0, 1'b0), "idle_again");

    // A request raised and dropped between two edges is never seen.
    @(negedge clk);
    bus_a.request = 4'b1000;
    #2;
    bus_a.request = 4'b0000;
    q_rr.push_back('{"pulse_ignored", pk(4'b0000, 1'b0, 2'd0, 1'b0)});

    drive_rr(1'b0, 4'b1000, pk(4'b1000, 1'b1, 2'd3, 1'b0), "rr_search_after0");
    drive_rr(1'b0, 4'b0101, pk(4'b0001, 1'b1, 2'd0, 1'b0), "rr_wraparound");
    drive_rr(1'b0, 4'b0100, pk(4'b0100, 1'b1, 2'd2, 1'b0), "handover_to2");

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q_async.push_back('{"async_rst_drop", pk(4'b0000, 1'b0, 2'd0, 1'b0)});
    -> async_ev;

    drive_rr(1'b0, 4'b0000, pk(4'b0000, 1'b0, 2'd0, 1'b0), "idle_after_async_rst");
    drive_rr(1'b0, 4'b1010, pk(4'b0010, 1'b1, 2'd1, 1'b0), "rr_restart_at0");
    drive_rr(1'b0, 4'b0000, pk(4'b0000, 1'b0, 2'd1, 1'b0), "rr_final_idle");

    drive_fp(4'b0100, pk(4'b0100, 1'b1, 2'd2, 1'b0), "fp_single");
    drive_fp(4'b1111, pk(4'b0100, 1'b1, 2'd2, 1'b0), "fp_owner_holds");
    drive_fp(4'b1111, pk(4'b0100, 1'b1, 2'd2, 1'b0), "fp_owner_holds");
    drive_fp(4'b1011, pk(4'b0001, 1'b1, 2'd0, 1'b0), "fp_owner2_drops");
    drive_fp(4'b1010, pk(4'b0010, 1'b1, 2'd1, 1'b0), "fp_next_lowest");
    drive_fp(4'b1000, pk(4'b1000, 1'b1, 2'd3, 1'b0), "fp_only3");
    drive_fp(4'b1001, pk(4'b1000, 1'b1, 2'd3, 1'b0), "fp_no_preempt");
    drive_fp(4'b0000, pk(4'b0000, 1'b0, 2'd3, 1'b0), "fp_idle");

    @(posedge clk);
    #2;
    checks++;
    if ((q_rr.size() + q_fp.size() + q_async.size()) != 0) begin
      failures++;
      $display("FAIL queues_drained: actual pending=%0d, required pending=0",
               q_rr.size() + q_fp.size() + q_async.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arb_param.md
WB_ARB_PARAM -- requirements
Module: wb_arb_param

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter IDX_W, default 2, grant index width, equal to ceil(log2(NUM_MASTERS)).
REQ-003 SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 selects fixed priority with the lowest index winning.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of consecutive owner cycles when contended (range 2..65535).
REQ-005 SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-007 SHALL have port request, input, NUM_MASTERS bits; bit i high means master i wants the bus.
REQ-008 SHALL have port grant, output, NUM_MASTERS bits; registered one-hot grant, or all-zero when idle.
REQ-009 SHALL have port grant_valid, output, 1 bit; high when any grant bit is high.
REQ-010 SHALL have port grant_idx, output, IDX_W bits; binary index of the granted master, held at the last owner's index when idle.
REQ-011 SHALL have port timeout_evt, output, 1 bit; one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 SHALL implement two states: IDLE (grant=0) and BUSY (exactly one grant bit high); grant SHALL never have more than one bit high.
REQ-013 In IDLE with request=0, the block SHALL remain in IDLE.
REQ-014 In IDLE with request!=0, the block SHALL select a winner and enter BUSY at the next rising edge (1-cycle latency).
REQ-015 In BUSY while request[owner]=1 and no timeout applies, the block SHALL hold the grant unchanged.
REQ-016 In BUSY when request[owner]=0 and another request is present, the block SHALL grant the new winner at that edge, with no idle cycle between owners.
REQ-017 In BUSY when request[owner]=0 and request=0, the block SHALL enter IDLE at that edge.
REQ-018 Round-robin selection (FIXED_PRIO=0) SHALL search indices last_owner+1, last_owner+2, ... modulo NUM_MASTERS, ending at last_owner itself; the first index with its request bit set wins.
REQ-019 The last_owner pointer SHALL update on every new grant and SHALL be retained through IDLE.
REQ-020 Fixed-priority selection (FIXED_PRIO=1) SHALL grant the lowest set request index; last_owner SHALL not affect the choice.
REQ-021 grant_idx and grant_valid SHALL be registered and SHALL change in the same cycle as grant.
REQ-022 A request pulse that is deasserted before it is sampled SHALL be ignored; no requests are queued.

Reset
REQ-023 Asserting rst SHALL immediately (asynchronously) force grant=0, grant_valid=0, grant_idx=0, timeout_evt=0, last_owner=NUM_MASTERS-1, hold counter=0, state=IDLE.
REQ-024 Asserting rst mid-ownership SHALL drop the grant without waiting for a clock edge.
REQ-025 After rst deasserts, the first round-robin search SHALL start at index 0.

Configuration
REQ-026 Macro WB_ARB_TIMEOUT_EN SHALL compile in a hold counter.
REQ-027 With WB_ARB_TIMEOUT_EN defined, the hold counter SHALL clear on every grant change, increment each cycle the owner keeps the grant, and saturate at TIMEOUT_CYCLES-1.
REQ-028 With WB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1, request[owner]=1, and any other request bit is high, the next edge SHALL grant the next winner as selected by REQ-018/REQ-020 excluding the owner, and SHALL pulse timeout_evt for one cycle.
REQ-029 With WB_ARB_TIMEOUT_EN defined, an uncontested owner SHALL keep the grant indefinitely.
REQ-030 Without WB_ARB_TIMEOUT_EN, the block SHALL contain no counter, timeout_evt SHALL be tied to 0, and TIMEOUT_CYCLES SHALL be ignored.

Verification (NUM_MASTERS=4)
REQ-031 Bench SHALL cover: rst pulse with request=0000 -> grant=0000, grant_valid=0, grant_idx=0 for 10 cycles.
REQ-032 Bench SHALL cover: from IDLE after reset, request=0110 -> next edge grant=0010, grant_idx=1, grant_valid=1.
REQ-033 Bench SHALL cover: owner 1, then request changes 0010->1001 -> same edge grant=1000, grant_idx=3; request->0000 -> grant=0000, and a subsequent request=1111 -> grant=0001.
REQ-034 Bench SHALL cover: WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, request=1111 held -> grant 0001 for 4 cycles, then 0010, 0100, 1000, 0001, with timeout_evt pulsing at each change.
REQ-035 Bench SHALL cover: FIXED_PRIO=1, owner 2 drops with request=1011 -> grant=0001.
REQ-036 Bench SHALL cover: rst asserted between clock edges while grant=0100 -> grant=0000 before the next edge.
